gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Memory-mapped GPIO controller sitting inside `soc` between the CPU peripheral bus and the per-pin `gpio_oe`/`gpio_do`/`gpio_di` lines that leave the SoC toward the pad ring. It owns the output-data and output-enable registers, synchronises pad inputs, detects edges and raises a level interrupt on enabled edge events. All CPU access to the pins goes through this block; nothing else drives `gpio_oe`/`gpio_do`.

## Interface
- `NR_GPIOS`, 8: number of pins, 1..32; register bits at and above `NR_GPIOS` are ignored on write and read as 0.
- `clk` in 1: sole clock.
- `reset_` in 1: reset, asynchronous, active-low; all flops clear on assertion.
- `cmd_valid` in 1: bus request valid.
- `cmd_ready` out 1: request accepted when `cmd_valid && cmd_ready`.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in 5: byte address; only `cmd_addr[4:2]` decoded.
- `cmd_wdata` in 32: write data, full-word writes only.
- `rsp_valid` out 1: read data valid, one-cycle pulse.
- `rsp_rdata` out 32: read data, 0 when `rsp_valid` low.
- `gpio_oe` out NR_GPIOS: per-pin output enable to pad.
- `gpio_do` out NR_GPIOS: per-pin output data to pad.
- `gpio_di` in NR_GPIOS: raw, asynchronous pad input.
- `irq` out 1: level interrupt to CPU.

## Operation
- Registers (word index = `cmd_addr[4:2]`): 0 DOUT rw; 1 OE rw; 2 DIN ro (synchronised input); 3 RISE_IE rw; 4 FALL_IE rw; 5 EVENT rw1c; 6 DOUT_SET wo (1 bits set DOUT); 7 DOUT_CLR wo (1 bits clear DOUT).
- Reads of index 6/7 return 0; writes to DIN ignored.
- `gpio_do` = DOUT, `gpio_oe` = OE, driven straight from registers.
- Input path per pin: two-flop synchroniser `s1`,`s2`, then `prev` flop; DIN = `s2`.
- rise = `s2 & ~prev`, fall = `~s2 & prev`; EVENT[i] sets when (rise & RISE_IE) | (fall & FALL_IE) and `armed`.
- `armed`: 2-bit counter after reset deassertion; edge detection disabled until 3 cycles after release so pins high at reset do not fake a rising edge.
- EVENT W1C: written 1 bits clear; a same-cycle new event on that bit wins (bit stays 1).
- `irq` registered: `irq <= |EVENT` (next-state value), so `irq` follows EVENT with no extra cycle.
- `cmd_ready` constant 1; no backpressure; no response on writes.
- Read pulse: `rsp_valid` high exactly one cycle after accepted read; back-to-back reads give back-to-back pulses.
- Read returns register value as of the accept cycle (before any same-cycle update).

## Timing
- Reset values: DOUT, OE, RISE_IE, FALL_IE, EVENT, `s1`,`s2`,`prev`, `armed` = 0; outputs `gpio_oe`=0, `gpio_do`=0, `irq`=0, `rsp_valid`=0, `rsp_rdata`=0, `cmd_ready`=1 once out of reset.
- Write at accept edge N: `gpio_do`/`gpio_oe` change after edge N.
- Pad change sampled at edge N: DIN updates at N+1, EVENT and `irq` at N+2.
- Read at accept edge N: `rsp_valid`/`rsp_rdata` valid after edge N, drop after N+1 unless another read accepted.
- Reset asserted mid-transaction: pending response discarded, all state cleared asynchronously.

## Structure
- Package `gpio_ctrl_pkg`: register index constants `GPIO_REG_DOUT`..`GPIO_REG_DOUT_CLR` (3-bit), data width 32.
- Sub-module `gpio_in_sync` (parameter `W`): synchroniser, `prev` flop, rise/fall outputs; instantiated once with `W=NR_GPIOS`.
- Register file, decode, EVENT/irq logic, arm counter in `gpio_ctrl`.

## Test plan
- Reset with `gpio_di`=8'hFF held: after release read EVENT (RISE_IE=8'hFF set) -> 0, `irq` stays 0.
- Write OE=8'h0F, DOUT=8'hA5, DOUT_SET=8'h02, DOUT_CLR=8'h80 -> `gpio_oe`=8'h0F, `gpio_do`=8'h27; read DOUT returns 32'h27 one cycle after accept.
- RISE_IE=8'h01, drive `gpio_di[0]` 0->1 -> DIN bit0 set 2 edges later, EVENT=8'h01 and `irq`=1 3 edges later; falling edge alone sets nothing.
- W1C EVENT=8'h01 in same cycle as new rise on pin 0 -> EVENT stays 8'h01, `irq` stays 1; W1C with no event -> EVENT 0, `irq` 0 next cycle.
- NR_GPIOS=8: write DOUT=32'hFFFF_FFFF -> read 32'h0000_00FF; reads of index 6/7 return 0.
- Assert `reset_` the cycle after a read accept -> `rsp_valid` 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO controller: register word indices and bus data width.
package gpio_ctrl_pkg;

    localparam int GPIO_DATA_W = 32;

    localparam logic [2:0] GPIO_REG_DOUT     = 3'd0;
    localparam logic [2:0] GPIO_REG_OE       = 3'd1;
    localparam logic [2:0] GPIO_REG_DIN      = 3'd2;
    localparam logic [2:0] GPIO_REG_RISE_IE  = 3'd3;
    localparam logic [2:0] GPIO_REG_FALL_IE  = 3'd4;
    localparam logic [2:0] GPIO_REG_EVENT    = 3'd5;
    localparam logic [2:0] GPIO_REG_DOUT_SET = 3'd6;
    localparam logic [2:0] GPIO_REG_DOUT_CLR = 3'd7;

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input conditioning: two-flop synchroniser followed by a history flop for edge detection.
module gpio_in_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: pin output registers, synchronised inputs and edge interrupts.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int NR_GPIOS = 8
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [4:0]             cmd_addr,
    input  logic [GPIO_DATA_W-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [GPIO_DATA_W-1:0] rsp_rdata,
    output logic [NR_GPIOS-1:0]    gpio_oe,
    output logic [NR_GPIOS-1:0]    gpio_do,
    input  logic [NR_GPIOS-1:0]    gpio_di,
    output logic                   irq
);

    logic [NR_GPIOS-1:0]    dout_q, dout_d;
    logic [NR_GPIOS-1:0]    oe_q, oe_d;
    logic [NR_GPIOS-1:0]    rise_ie_q, rise_ie_d;
    logic [NR_GPIOS-1:0]    fall_ie_q, fall_ie_d;
    logic [NR_GPIOS-1:0]    event_q, event_d;
    logic [1:0]             arm_q, arm_d;
    logic                   irq_q;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [GPIO_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NR_GPIOS-1:0]    din_sync, din_rise, din_fall;
    logic [NR_GPIOS-1:0]    wdat, w1c, new_ev, rd_pins;
    logic [2:0]             idx;
    logic                   wr_en, rd_en, armed;
    logic                   unused_bits;

    gpio_in_sync #(.W(NR_GPIOS)) u_in_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din_i  (gpio_di),
        .sync_o (din_sync),
        .rise_o (din_rise),
        .fall_o (din_fall)
    );

    assign cmd_ready   = 1'b1;
    assign unused_bits = ^{cmd_addr[1:0], cmd_wdata};

    always_comb begin
        wr_en     = cmd_valid & cmd_ready & cmd_wr;
        rd_en     = cmd_valid & cmd_ready & ~cmd_wr;
        idx       = cmd_addr[4:2];
        wdat      = cmd_wdata[NR_GPIOS-1:0];
        dout_d    = dout_q;
        oe_d      = oe_q;
        rise_ie_d = rise_ie_q;
        fall_ie_d = fall_ie_q;
        w1c       = '0;

        if (wr_en) begin
            case (idx)
                GPIO_REG_DOUT:     dout_d    = wdat;
                GPIO_REG_OE:       oe_d      = wdat;
                GPIO_REG_RISE_IE:  rise_ie_d = wdat;
                GPIO_REG_FALL_IE:  fall_ie_d = wdat;
                GPIO_REG_EVENT:    w1c       = wdat;
                GPIO_REG_DOUT_SET: dout_d    = dout_q | wdat;
                GPIO_REG_DOUT_CLR: dout_d    = dout_q & ~wdat;
                default:           ;
            endcase
        end

        // Pins already high at reset release would otherwise look like a rising edge.
        armed   = (arm_q == 2'd3);
        arm_d   = armed ? arm_q : arm_q + 2'd1;
        new_ev  = armed ? ((din_rise & rise_ie_q) | (din_fall & fall_ie_q)) : '0;
        event_d = (event_q & ~w1c) | new_ev;

        case (idx)
            GPIO_REG_DOUT:    rd_pins = dout_q;
            GPIO_REG_OE:      rd_pins = oe_q;
            GPIO_REG_DIN:     rd_pins = din_sync;
            GPIO_REG_RISE_IE: rd_pins = rise_ie_q;
            GPIO_REG_FALL_IE: rd_pins = fall_ie_q;
            GPIO_REG_EVENT:   rd_pins = event_q;
            default:          rd_pins = '0;
        endcase

        rsp_valid_d = rd_en;
        rsp_rdata_d = '0;
        if (rd_en) begin
            rsp_rdata_d[NR_GPIOS-1:0] = rd_pins;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            dout_q      <= '0;
            oe_q        <= '0;
            rise_ie_q   <= '0;
            fall_ie_q   <= '0;
            event_q     <= '0;
            arm_q       <= '0;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rise_ie_q   <= rise_ie_d;
            fall_ie_q   <= fall_ie_d;
            event_q     <= event_d;
            arm_q       <= arm_d;
            irq_q       <= |event_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign gpio_do   = dout_q;
    assign gpio_oe   = oe_q;
    assign irq       = irq_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: directed scenarios plus randomized traffic against a cycle-level register model.
module tb_gpio_ctrl;
    import gpio_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_do;
    logic [7:0]  gpio_di = '0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_ctrl #(.NR_GPIOS(8)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .gpio_oe   (gpio_oe),
        .gpio_do   (gpio_do),
        .gpio_di   (gpio_di),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus a history of pad samples
    // (pad_h[0] newest sample, pad_h[1] what software sees as DIN, pad_h[2] the one before).
    logic [7:0]  m_dout, m_oe, m_rie, m_fie, m_ev;
    logic        m_irq, m_rv;
    logic [31:0] m_rd;
    logic [7:0]  pad_h [3];
    int          m_age;

    task automatic model_reset();
        m_dout = '0; m_oe = '0; m_rie = '0; m_fie = '0; m_ev = '0;
        m_irq = 1'b0; m_rv = 1'b0; m_rd = '0;
        pad_h[0] = '0; pad_h[1] = '0; pad_h[2] = '0;
        m_age = 0;
    endtask

    task automatic tick();
        logic [7:0] din, prev, edges, wd, w1c;
        logic [7:0] regs [8];
        logic [2:0] idx;
        din   = pad_h[1];
        prev  = pad_h[2];
        edges = (m_age >= 3) ? ((din & ~prev & m_rie) | (~din & prev & m_fie)) : 8'h00;
        regs  = '{m_dout, m_oe, din, m_rie, m_fie, m_ev, 8'h00, 8'h00};
        idx   = cmd_addr[4:2];
        wd    = cmd_wdata[7:0];
        w1c   = 8'h00;
        m_rv  = cmd_valid && !cmd_wr;
        m_rd  = m_rv ? {24'h0, regs[idx]} : 32'h0;
        if (cmd_valid && cmd_wr) begin
            case (idx)
                3'd0: m_dout = wd;
                3'd1: m_oe   = wd;
                3'd3: m_rie  = wd;
                3'd4: m_fie  = wd;
                3'd5: w1c    = wd;
                3'd6: m_dout = m_dout | wd;
                3'd7: m_dout = m_dout & ~wd;
                default: ;
            endcase
        end
        m_ev     = (m_ev & ~w1c) | edges;
        m_irq    = |m_ev;
        pad_h[2] = pad_h[1];
        pad_h[1] = pad_h[0];
        pad_h[0] = gpio_di;
        m_age++;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [2:0] idx, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = {idx, 2'b00};
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_wdata = '0;
    endtask

    task automatic test_reset();
        reset_  = 1'b0;
        gpio_di = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: do=%h oe=%h irq=%b rv=%b rd=%h, want all 0",
                     gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata);
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        reset_ = 1'b1;
        model_reset();
        bus(1'b1, GPIO_REG_RISE_IE, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_fake_edge_irq cyc %0d: got %b want 0", i, irq);
            end
        end
        bus(1'b0, GPIO_REG_EVENT, 32'h0);
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_event_read: got rv=%b rd=%h want rv=1 rd=0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_dout();
        bus(1'b1, GPIO_REG_OE,       32'h0F);
        bus(1'b1, GPIO_REG_DOUT,     32'hA5);
        bus(1'b1, GPIO_REG_DOUT_SET, 32'h02);
        bus(1'b1, GPIO_REG_DOUT_CLR, 32'h80);
        n_tests++;
        if ({gpio_oe, gpio_do} !== {8'h0F, 8'h27}) begin
            n_fail++;
            $display("FAIL dout_pins: got oe=%h do=%h want oe=0f do=27", gpio_oe, gpio_do);
        end
        bus(1'b0, GPIO_REG_DOUT, 32'h0);
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h27}) begin
            n_fail++;
            $display("FAIL dout_read: got rv=%b rd=%h want rv=1 rd=27", rsp_valid, rsp_rdata);
        end
        tick();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL dout_read_drop: got rv=%b rd=%h want 0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_rise_event();
        bus(1'b1, GPIO_REG_RISE_IE, 32'h01);
        bus(1'b1, GPIO_REG_FALL_IE, 32'h00);
        gpio_di = 8'h00;
        repeat (4) tick();
        bus(1'b1, GPIO_REG_EVENT, 32'hFF);
        gpio_di = 8'h01;
        tick();
        tick();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_irq_early: got %b want 0", irq);
        end
        bus(1'b0, GPIO_REG_DIN, 32'h0);
        n_tests++;
        if ({irq, rsp_rdata} !== {1'b1, 32'h01}) begin
            n_fail++;
            $display("FAIL rise_din_irq: got irq=%b din=%h want irq=1 din=01", irq, rsp_rdata);
        end
        bus(1'b0, GPIO_REG_EVENT, 32'h0);
        n_tests++;
        if (rsp_rdata !== 32'h01) begin
            n_fail++;
            $display("FAIL rise_event: got %h want 01", rsp_rdata);
        end
        bus(1'b1, GPIO_REG_EVENT, 32'h01);
        gpio_di = 8'h00;
        repeat (5) tick();
        bus(1'b0, GPIO_REG_EVENT, 32'h0);
        n_tests++;
        if ({irq, rsp_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL fall_ignored: got irq=%b event=%h want 0", irq, rsp_rdata);
        end
    endtask

    task automatic test_w1c_collision();
        gpio_di = 8'h01;
        repeat (3) tick();
        gpio_di = 8'h00;
        repeat (3) tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_setup_irq: got %b want 1", irq);
        end
        gpio_di = 8'h01;
        tick();
        tick();
        bus(1'b1, GPIO_REG_EVENT, 32'h01);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_collision_irq: got %b want 1", irq);
        end
        bus(1'b0, GPIO_REG_EVENT, 32'h0);
        n_tests++;
        if (rsp_rdata !== 32'h01) begin
            n_fail++;
            $display("FAIL w1c_collision_event: got %h want 01", rsp_rdata);
        end
        bus(1'b1, GPIO_REG_EVENT, 32'h01);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_clear_irq: got %b want 0", irq);
        end
        bus(1'b0, GPIO_REG_EVENT, 32'h0);
        n_tests++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear_event: got %h want 0", rsp_rdata);
        end
    endtask

    task automatic test_width();
        bus(1'b1, GPIO_REG_DOUT, 32'hFFFF_FFFF);
        bus(1'b0, GPIO_REG_DOUT, 32'h0);
        n_tests++;
        if ({gpio_do, rsp_rdata} !== {8'hFF, 32'h0000_00FF}) begin
            n_fail++;
            $display("FAIL width_dout: got do=%h rd=%h want do=ff rd=000000ff", gpio_do, rsp_rdata);
        end
        bus(1'b0, GPIO_REG_DOUT_SET, 32'h0);
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL read_idx6: got rv=%b rd=%h want rv=1 rd=0", rsp_valid, rsp_rdata);
        end
        bus(1'b0, GPIO_REG_DOUT_CLR, 32'h0);
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL read_idx7: got rv=%b rd=%h want rv=1 rd=0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bus(1'b1, GPIO_REG_OE,      32'h3C);
        bus(1'b1, GPIO_REG_FALL_IE, 32'h5A);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = {GPIO_REG_OE, 2'b00};
        tick();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h3C}) begin
            n_fail++;
            $display("FAIL b2b_first: got rv=%b rd=%h want rv=1 rd=3c", rsp_valid, rsp_rdata);
        end
        cmd_addr = {GPIO_REG_FALL_IE, 2'b00};
        tick();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h5A}) begin
            n_fail++;
            $display("FAIL b2b_second: got rv=%b rd=%h want rv=1 rd=5a", rsp_valid, rsp_rdata);
        end
        cmd_valid = 1'b0;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL b2b_drop: got rv=%b rd=%h want 0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bus(1'b0, GPIO_REG_OE, 32'h0);
        n_tests++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_valid: got %b want 1", rsp_valid);
        end
        reset_ = 1'b0;
        #1;
        n_tests++;
        if ({gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata} !== 50'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: do=%h oe=%h irq=%b rv=%b rd=%h, want all 0",
                     gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_wr    = 1'($urandom_range(0, 1));
            cmd_addr  = 5'($urandom);
            cmd_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_di = 8'($urandom);
            tick();
            n_tests++;
            if ({gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata} !==
                {m_dout, m_oe, m_irq, m_rv, m_rd}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got do=%h oe=%h irq=%b rv=%b rd=%h want do=%h oe=%h irq=%b rv=%b rd=%h",
                         i, gpio_do, gpio_oe, irq, rsp_valid, rsp_rdata,
                         m_dout, m_oe, m_irq, m_rv, m_rd);
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dout();
        test_rise_event();
        test_w1c_collision();
        test_width();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
